// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache sitting between the fetch stage
// and the line-wide ram. Hits return one cycle after acceptance; misses pull
// a whole 64-byte line in a single beat, install it, then replay the lookup.
module icache #(
  parameter int LINES  = 8,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  input  logic              flush,
  output logic              mem_cs,
  output logic              mem_we,
  output logic              mem_addr_valid,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_data_ready,
  input  logic [511:0]      mem_data
);

  localparam int IW = $clog2(LINES);
  localparam int TW = ADDR_W - 6 - IW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_FILL
  } state_t;

  state_t            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TW-1:0]     tag_q  [LINES];
  logic [511:0]      data_q [LINES];
  logic [ADDR_W-1:0] addr_q;

  logic [IW-1:0]     idx;
  logic [TW-1:0]     tag;
  logic [3:0]        wsel;
  logic              hit;
  logic              accept;
  logic              install;
  logic [31:0]       word;
  logic              unused_lsb;

  // Byte-lane bits of the fetch address never reach the cache state.
  assign unused_lsb = ^addr_q[1:0];

  assign idx  = addr_q[6+IW-1:6];
  assign tag  = addr_q[ADDR_W-1:6+IW];
  assign wsel = addr_q[5:2];

  // Array reads are combinational on the registered index.
  assign hit  = valid_q[idx] && (tag_q[idx] == tag);
  assign word = data_q[idx][{wsel, 5'b0} +: 32];

  assign accept  = req_valid && req_ready;
  // A fill landing on a flush edge is thrown away.
  assign install = (state_q == S_FILL) && mem_data_ready && !flush;

  // Control state: FSM and valid bits, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  // Datapath state: captured address, tags and line data need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= req_addr;
    end
    if (install) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= mem_data;
    end
  end

  // Next-state logic; flush overrides everything and wipes every line.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        state_d = hit ? S_IDLE : S_FILL;
      end
      S_FILL: begin
        if (mem_data_ready) begin
          valid_d[idx] = 1'b1;
          state_d      = S_LOOKUP;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      valid_d = '0;
    end
  end

  // Output decode from registered state; everything idles at zero in reset.
  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_data      = '0;
    mem_cs         = 1'b0;
    mem_we         = 1'b0;
    mem_addr_valid = 1'b0;
    mem_addr       = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = rst_n && !flush;
      end
      S_LOOKUP: begin
        // A flush in the response cycle drops the outstanding request.
        resp_valid = hit && !flush;
        resp_data  = (hit && !flush) ? word : 32'h0;
      end
      S_FILL: begin
        mem_cs         = 1'b1;
        mem_addr_valid = 1'b1;
        mem_addr       = {addr_q[ADDR_W-1:6], 6'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: directed fetches push expected word and
// latency; a monitor pops on every resp_valid; a ram model serves fills.
module tb_icache;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [14:0]   req_addr = '0;
  logic          req_ready;
  logic          resp_valid;
  logic [31:0]   resp_data;
  logic          flush = 1'b0;
  logic          mem_cs;
  logic          mem_we;
  logic          mem_addr_valid;
  logic [14:0]   mem_addr;
  logic          mem_data_ready = 1'b0;
  logic [511:0]  mem_data = '0;

  always #5 clk = ~clk;

  icache #(.LINES(8), .ADDR_W(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .flush(flush),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr_valid(mem_addr_valid),
    .mem_addr(mem_addr), .mem_data_ready(mem_data_ready), .mem_data(mem_data)
  );

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t         sbq[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  int           last_acc = 0;
  int           slow = 0;
  int           wcnt = 0;
  int           fills = 0;
  bit           in_fill = 0;
  logic [14:0]  exp_fill_addr = '0;
  logic [511:0] ram_lines [512];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each response and polices idle outputs.
  always @(negedge clk) begin
    if (rst_n) begin
      check("mem_we", mem_we, 0);
      if (resp_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_resp", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("resp_data", resp_data, e.data);
          check("latency", cyc - last_acc + 1, e.lat);
        end
      end else begin
        check("resp_data_idle", resp_data, 0);
      end
      if (!mem_cs) begin
        check("mem_addr_idle", mem_addr, 0);
        check("mem_addr_valid_idle", mem_addr_valid, 0);
      end
    end
  end

  // Ram model: answers a fill after 'slow' wait cycles, checks stable request.
  always @(negedge clk) begin
    if (mem_cs && mem_addr_valid) begin
      if (!in_fill) fills++;
      in_fill = 1;
      check("fill_addr", mem_addr, exp_fill_addr);
      check("ready_in_fill", req_ready, 0);
      if (wcnt >= slow) begin
        mem_data_ready = 1'b1;
        mem_data       = ram_lines[mem_addr[14:6]];
      end else begin
        mem_data_ready = 1'b0;
        mem_data       = '0;
        wcnt++;
      end
    end else begin
      in_fill        = 0;
      wcnt           = 0;
      mem_data_ready = 1'b0;
      mem_data       = '0;
    end
  end

  // One fetch: push expectation, hand it over, wait for the monitor to drain.
  task automatic do_req(input logic [14:0] a, input logic [31:0] d, input int lat, input bit miss);
    int f0;
    int n;
    f0 = fills;
    exp_fill_addr = {a[14:6], 6'b0};
    sbq.push_back('{data: d, lat: lat});
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 1, 0);
      req_valid = 1'b0;
      sbq.delete();
      return;
    end
    @(posedge clk);
    #1 last_acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      check("resp_timeout", 1, 0);
      sbq.delete();
    end
    check("fill_count", fills - f0, miss ? 1 : 0);
  endtask

  // Starts a request that must never be answered (dropped by flush/reset).
  task automatic start_fill(input logic [14:0] a);
    exp_fill_addr = {a[14:6], 6'b0};
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int l = 0; l < 512; l++)
      for (int k = 0; k < 64; k++)
        ram_lines[l][8*k +: 8] = 8'(l * 4 + k);
    ram_lines[1][63:0] = 64'h8877665544332211;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_mem_cs", mem_cs, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1);

    // Cold miss, hit, conflict refill.
    do_req(15'h0044, 32'h88776655, 3, 1);
    do_req(15'h0040, 32'h44332211, 1, 0);
    do_req(15'h0000, 32'h03020100, 3, 1);
    do_req(15'h0200, 32'h23222120, 3, 1);
    do_req(15'h0004, 32'h07060504, 3, 1);
    do_req(15'h0044, 32'h88776655, 1, 0);

    // Slow memory: five wait cycles.
    slow = 5;
    do_req(15'h008C, 32'h17161514, 8, 1);
    slow = 0;

    // Flush while a fill is pending.
    slow = 3;
    start_fill(15'h00C0);
    check("in_fill_before_flush", mem_cs, 1);
    flush = 1'b1;
    #1 check("ready_during_flush", req_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    check("flush_mem_cs", mem_cs, 0);
    #1 check("ready_after_flush", req_ready, 1);
    repeat (6) @(negedge clk);
    slow = 0;
    do_req(15'h0044, 32'h88776655, 3, 1);

    // Reset in the middle of a fill.
    slow = 10;
    start_fill(15'h0100);
    check("in_fill_before_reset", mem_cs, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_fill_mem_cs", mem_cs, 0);
    check("rst_fill_mem_addr_valid", mem_addr_valid, 0);
    check("rst_fill_mem_addr", mem_addr, 0);
    check("rst_fill_req_ready", req_ready, 0);
    check("rst_fill_resp_valid", resp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    slow = 0;
    do_req(15'h0100, 32'h13121110, 3, 1);
    do_req(15'h0044, 32'h88776655, 3, 1);
    do_req(15'h0100, 32'h13121110, 1, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the core fetch stage and the `ram` block. It accepts 32-bit word fetch requests and returns the word on a hit one cycle after acceptance. On a miss it fetches the whole 64-byte line from `ram` over its single-beat 512-bit read interface, installs the line, then replays the lookup.

## Interface
Parameters:
- `LINES`, default 8: number of cache lines; power of two, at least 2. Index width `IW = log2(LINES)`.
- `ADDR_W`, default 15: byte address width, matching the `ram` address.

Ports:
- `clk` in, 1: single clock; all state changes on the rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `req_valid` in, 1: core fetch request.
- `req_addr` in, ADDR_W: byte address; bits [1:0] are ignored.
- `req_ready` out, 1: request is accepted on any edge where `req_valid & req_ready`.
- `resp_valid` out, 1: one-cycle pulse; `resp_data` is valid in that cycle.
- `resp_data` out, 32: fetched word.
- `flush` in, 1: invalidate all lines.
- `mem_cs` out, 1: chip select to `ram`.
- `mem_we` out, 1: write enable to `ram`; tied to 0.
- `mem_addr_valid` out, 1: address valid to `ram`.
- `mem_addr` out, ADDR_W: line-aligned address to `ram`.
- `mem_data_ready` in, 1: line data is valid this cycle.
- `mem_data` in, 512: line data; byte k is in bits [8k+7:8k].

## Operation
- Address split: offset = `addr[5:0]`, word select = `addr[5:2]`, index = `addr[6+IW-1:6]`, tag = `addr[ADDR_W-1:6+IW]`.
- Storage per line: valid bit, tag, 512-bit data. Word w of a line is data bits [32w+31:32w].
- FSM states: IDLE, LOOKUP, FILL.
- IDLE: `req_ready`=1. On accept, register the address and go to LOOKUP.
- LOOKUP: a hit means the indexed line is valid and its tag matches.
  - Hit: `resp_valid`=1, `resp_data` = selected word, go to IDLE.
  - Miss: go to FILL.
- FILL: `mem_cs`=`mem_addr_valid`=1 and `mem_addr` = {registered tag, index, 6'b0}. On the edge where `mem_data_ready`=1, write data and tag, set the valid bit, and go to LOOKUP, which then hits.
- `req_ready`=0 in LOOKUP and FILL. Peak throughput is one request every 2 cycles.
- `resp_data` is 0 whenever `resp_valid`=0.
- `mem_cs` and `mem_addr_valid` are 0 outside FILL; `mem_addr` is 0 outside FILL. `mem_we` is always 0.
- Flush:
  - On any edge with `flush`=1, all valid bits are cleared and the state goes to IDLE.
  - Any outstanding request is dropped with no response.
  - A fill completing on the same edge is discarded.
  - A request presented in IDLE on a flush edge is not accepted; `req_ready` is forced to 0 while `flush`=1.
- Reset: state IDLE, all valid bits 0, all outputs 0. Tag and data arrays need no reset.

## Timing
- Hit: accept at edge E0; `resp_valid` is high in the cycle after E0.
- Miss: accept at E0, LOOKUP fails, FILL starts in the cycle after the next edge (E1).
  - With `ram` returning `mem_data_ready` in the same cycle, the install happens at E2 and `resp_valid` is high in the cycle after E2 (3-cycle latency).
  - Each extra wait cycle in FILL adds one cycle.
- All outputs are registered-state decodes; there is no combinational path from `req_*` to outputs. Data-array reads are combinational on the registered index.
- Reset asserted mid-FILL drops `mem_cs` immediately (asynchronous) and leaves no valid lines.

## Test plan
- Cold miss: reset, request 0x0044 with `ram` line 1 bytes 0x40..0x47 = 11 22 33 44 55 66 77 88 → `mem_addr`=0x0040 in FILL; `resp_data`=0x88776655 three cycles after accept.
- Hit: then request 0x0040 → `resp_data`=0x44332211 one cycle after accept; `mem_cs` stays 0.
- Conflict: with LINES=8, request 0x0200 (same index 0 as 0x0000, different tag) after 0x0000 is cached → refill from 0x0200. A later 0x0000 misses again.
- Slow memory: hold `mem_data_ready`=0 for 5 cycles in FILL → `mem_cs`/`mem_addr` stay stable, `req_ready`=0 throughout, response arrives 5 cycles later than the baseline.
- Flush: flush while in FILL → state IDLE, no `resp_valid`. The next request to a previously cached line misses.
- Reset mid-fill: deassert `rst_n` during FILL → all outputs 0 the same cycle. After release, a request to the same address misses.
